// File: rtl/key_loader.sv
// key_loader: receives an unlock key as a valid/ready byte stream, verifies an
// XOR checksum, and only then commits the key to the held key bus that feeds the
// locked netlist. Repeated bad loads latch a permanent lockout (cleared by rst_n).
module key_loader #(
   parameter int KEY_WIDTH = 32,
   parameter int MAX_FAIL  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   input  logic                 zeroize,
   output logic [KEY_WIDTH-1:0] key_out,
   output logic                 key_valid,
   output logic                 busy,
   output logic                 load_err,
   output logic                 lockout
);

   localparam int NBYTES = KEY_WIDTH / 8;
   localparam int CNT_W  = $clog2(NBYTES + 1);
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);

   // byte_cnt value at which the incoming byte is the checksum rather than key data
   localparam logic [CNT_W-1:0]  CSUM_CNT  = CNT_W'(NBYTES);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_LOCK
   } state_t;

   state_t                state_q;
   logic [KEY_WIDTH-1:0]  shadow_q;
   logic [KEY_WIDTH-1:0]  key_q;
   logic                  key_valid_q;
   logic [7:0]            xor_acc_q;
   logic [CNT_W-1:0]      byte_cnt_q;
   logic [FAIL_W-1:0]     fail_cnt_q;
   logic                  match_q;

   logic                  xfer;
   logic                  zero_req;
   logic [FAIL_W-1:0]     fail_cnt_d;
   logic                  lock_next_d;

   // Handshake and status outputs decoded from the registered state; in_ready is
   // also gated by zeroize so no byte slips in during a wipe cycle.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      load_err = 1'b0;
      lockout  = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = ~zeroize;
         end
         S_LOAD: begin
            in_ready = ~zeroize;
            busy     = 1'b1;
         end
         S_CHECK: begin
            busy     = 1'b1;
            // a wipe in the check cycle overrides the verdict, so no error pulse
            load_err = ~match_q & ~zeroize;
         end
         S_LOCK: begin
            lockout  = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Transfer qualification and the saturating failure count used on mismatch.
   always_comb begin
      xfer        = in_valid & in_ready;
      zero_req    = zeroize & (state_q != S_LOCK);
      fail_cnt_d  = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : (fail_cnt_q + 1'b1);
      lock_next_d = (fail_cnt_q == FAIL_LAST);
   end

   assign key_out   = key_q;
   assign key_valid = key_valid_q;

   // Load FSM: collects key bytes into the shadow, verifies, commits or counts a failure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shadow_q    <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         xor_acc_q   <= '0;
         byte_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         match_q     <= 1'b0;
      end else if (zero_req) begin
         // wipe everything key-related but keep the failure history
         state_q     <= S_IDLE;
         shadow_q    <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         xor_acc_q   <= '0;
         byte_cnt_q  <= '0;
         match_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  // starting a new frame retracts any previously committed key
                  shadow_q    <= KEY_WIDTH'(in_data);
                  xor_acc_q   <= in_data;
                  byte_cnt_q  <= CNT_W'(1);
                  key_q       <= '0;
                  key_valid_q <= 1'b0;
                  state_q     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  if (byte_cnt_q == CSUM_CNT) begin
                     match_q <= (in_data == xor_acc_q);
                     state_q <= S_CHECK;
                  end else begin
                     for (int j = 0; j < NBYTES; j++) begin
                        if (byte_cnt_q == CNT_W'(j)) begin
                           shadow_q[8*j +: 8] <= in_data;
                        end
                     end
                     xor_acc_q  <= xor_acc_q ^ in_data;
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end
            end
            S_CHECK: begin
               if (match_q) begin
                  key_q       <= shadow_q;
                  key_valid_q <= 1'b1;
                  fail_cnt_q  <= '0;
                  state_q     <= S_IDLE;
               end else begin
                  key_q       <= '0;
                  key_valid_q <= 1'b0;
                  fail_cnt_q  <= fail_cnt_d;
                  state_q     <= lock_next_d ? S_LOCK : S_IDLE;
               end
               shadow_q   <= '0;
               xor_acc_q  <= '0;
               byte_cnt_q <= '0;
               match_q    <= 1'b0;
            end
            S_LOCK: begin
               // terminal: key bus forced to zero until reset
               key_q       <= '0;
               key_valid_q <= 1'b0;
               state_q     <= S_LOCK;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
